execute_pipe: RTL and testbench
===============================

# execute_pipe

Parametrised, handshaked successor to the single-cycle execute stage. Accepts one operation per cycle under valid/ready, computes integer results internally in one cycle, and issues float operations to an external fully pipelined FPU of fixed latency `FLAT`. Results and condition-register nibbles return strictly in issue order through a credit-protected output FIFO, so writeback may stall without losing in-flight FPU results. It sits between decode/issue and writeback.

## Interface
- `XLEN`, 32: operand and result width; power of two, at least 8.
- `FLAT`, 4: FPU latency in cycles; at least 1.
- `DEPTH`, 4: output FIFO entries; at least 2.
- `TAGW`, 5: width of the destination tag that travels with each operation.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset; asynchronous, active-high.
- `in_valid`  in  1: an operation is offered.
- `in_ready`  out  1: the operation is accepted when `in_valid & in_ready`.
- `in_is_float`  in  1: 1 = FPU operation, 0 = integer operation.
- `in_op`  in  4: integer op in `[2:0]`; FPU op code, passed through unchanged.
- `in_a`, `in_b`  in  XLEN: operands.
- `in_tag`  in  TAGW: destination tag.
- `fpu_in_valid`  out  1: issue strobe to the FPU.
- `fpu_op`  out  4: FPU op code.
- `fpu_a`, `fpu_b`  out  XLEN: FPU operands.
- `fpu_result`  in  XLEN: FPU result, valid exactly `FLAT` cycles after issue.
- `fpu_cr`  in  4: FPU compare nibble, same timing as `fpu_result`.
- `out_valid`  out  1: the FIFO head is valid.
- `out_ready`  in  1: writeback consumes the head.
- `out_data`  out  XLEN: result.
- `out_cr`  out  4: condition nibble.
- `out_tag`  out  TAGW: destination tag.

## Operation
- Integer ops: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra. Shift amount is `in_b[log2(XLEN)-1:0]`. Arithmetic wraps modulo 2^XLEN.
- Integer `out_cr` is a signed compare of a and b on every op: 1000 if a<b, 0100 if a>b, 0010 if equal.
- Float path: `fpu_in_valid = in_valid & in_ready & in_is_float`. `fpu_op`, `fpu_a` and `fpu_b` are driven from the inputs combinationally.
- A `FLAT`-stage delay line of {valid, tag} tracks in-flight FPU ops. When the last stage is valid, `fpu_result`, `fpu_cr` and the tag are written to the FIFO.
- Credit rule: `used = fifo_count + float_inflight + int_stage_valid`. `in_ready` requires `used < DEPTH`. The FIFO therefore never overflows.
- Order rule: an integer op is not accepted while `float_inflight != 0`. Consequently `in_ready = !rst && used < DEPTH && (in_is_float || float_inflight == 0)`. Upstream must hold `in_is_float` stable while `in_valid` is high.
- `in_ready` never depends on `out_ready`. A slot freed by a pop returns credit in the following cycle.
- FIFO write and pop on the same edge leave the count unchanged. A pop from an empty FIFO cannot occur.
- Reset at any time: FIFO emptied, delay line and integer stage cleared. FPU results still arriving after reset are ignored.

## Timing
- Reset values: `out_valid` 0, `out_data` 0, `out_cr` 0, `out_tag` 0, `fpu_in_valid` 0, `in_ready` 0.
- Integer op accepted at edge E is written to the FIFO at E+1. With the FIFO empty, `out_valid` is high after E+1.
- Float op accepted at edge E is written to the FIFO at E+FLAT. With the FIFO empty, `out_valid` is high after E+FLAT.
- Throughput is 1 op/cycle while credits last. A float followed by an integer op stalls the integer op until the float reaches the FIFO.
- `out_*` hold stable while `out_valid & !out_ready`.

## Structure
- Package `exec_pkg`: integer op encodings `ALU_ADD` to `ALU_SRA`, CR constants `CR_LT`/`CR_GT`/`CR_EQ`, and a `result_t` struct {data, cr, tag}.
- Sub-module `result_fifo`: synchronous FIFO parametrised by `DEPTH` and entry width, with count output. The integer ALU and the delay line live in `execute_pipe`.

## Test plan
- Integer add: a=5, b=−3 (0xFFFFFFFD), op 0, tag 7 → one cycle later data=2, cr=0100, tag=7.
- Issue sra then sll with a=0x80000000, b=4 → data 0xF8000000 then 0x00000000, in order.
- Float tag 1 then integer tag 2 back-to-back with FLAT=4 → `in_ready` low for the integer op until the float enters the FIFO; outputs tag 1 then tag 2.
- `out_ready`=0, issue 6 floats with DEPTH=4 → exactly 4 accepted and `in_ready` stays low. Raising `out_ready` drains tags in order with no loss.
- Full FIFO with simultaneous pop and write → count unchanged, `in_ready` rises only on the next cycle.
- Assert `rst` with 2 floats in flight and 1 FIFO entry → `out_valid`=0 immediately. Late `fpu_result` is never output; after release the first new op returns correctly.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared encodings and the result record for the execute pipe.
// result_t is the default-width (XLEN=32, TAGW=5) view of one FIFO entry.
package exec_pkg;
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;
  localparam logic [2:0] ALU_SRL = 3'd6;
  localparam logic [2:0] ALU_SRA = 3'd7;

  localparam logic [3:0] CR_LT = 4'b1000;
  localparam logic [3:0] CR_GT = 4'b0100;
  localparam logic [3:0] CR_EQ = 4'b0010;

  localparam int RES_XLEN = 32;
  localparam int RES_TAGW = 5;

  typedef struct packed {
    logic [RES_XLEN-1:0] data;
    logic [3:0]          cr;
    logic [RES_TAGW-1:0] tag;
  } result_t;
endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH need not be a power of two.
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [W-1:0]                 wr_data,
  input  logic                         rd_en,
  output logic [W-1:0]                 rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = inc(wr_ptr_q);
    end
    if (rd_en) rd_ptr_d = inc(rd_ptr_q);
    cnt_d = cnt_q + CW'(wr_en) - CW'(rd_en);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = cnt_q;
endmodule

// File: rtl/execute_pipe.sv
// Handshaked execute stage: 1-cycle integer ALU plus a fixed-latency external FPU,
// results retired in issue order through a credit-protected FIFO.
module execute_pipe
  import exec_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int FLAT  = 4,
  parameter int DEPTH = 4,
  parameter int TAGW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_is_float,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [TAGW-1:0] in_tag,
  output logic            fpu_in_valid,
  output logic [3:0]      fpu_op,
  output logic [XLEN-1:0] fpu_a,
  output logic [XLEN-1:0] fpu_b,
  input  logic [XLEN-1:0] fpu_result,
  input  logic [3:0]      fpu_cr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [3:0]      out_cr,
  output logic [TAGW-1:0] out_tag
);
  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(DEPTH+1);

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [3:0]      cr;
    logic [TAGW-1:0] tag;
  } entry_t;

  logic                       int_vld_q, int_vld_d;
  entry_t                     int_res_q, int_res_d;
  logic [FLAT-1:0]            fl_vld_q, fl_vld_d;
  logic [FLAT-1:0][TAGW-1:0]  fl_tag_q, fl_tag_d;

  logic [CW-1:0]   fifo_count;
  logic [31:0]     inflight, used;
  logic            accept, wr_en, rd_en;
  logic [XLEN-1:0] alu;
  logic [3:0]      cr;
  entry_t          wr_entry, rd_entry;

  // Credits count everything already committed to land in the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < FLAT; i++) inflight = inflight + 32'(fl_vld_q[i]);
    used     = 32'(fifo_count) + inflight + 32'(int_vld_q);
    in_ready = !rst && (used < 32'(DEPTH)) && (in_is_float || inflight == '0);
    accept   = in_valid & in_ready;
  end

  assign fpu_in_valid = accept & in_is_float;
  assign fpu_op       = in_op;
  assign fpu_a        = in_a;
  assign fpu_b        = in_b;

  always_comb begin
    case (in_op[2:0])
      ALU_ADD: alu = in_a + in_b;
      ALU_SUB: alu = in_a - in_b;
      ALU_AND: alu = in_a & in_b;
      ALU_OR:  alu = in_a | in_b;
      ALU_XOR: alu = in_a ^ in_b;
      ALU_SLL: alu = in_a << in_b[SHW-1:0];
      ALU_SRL: alu = in_a >> in_b[SHW-1:0];
      ALU_SRA: alu = $signed(in_a) >>> in_b[SHW-1:0];
      default: alu = '0;
    endcase
    if ($signed(in_a) < $signed(in_b))      cr = CR_LT;
    else if ($signed(in_a) > $signed(in_b)) cr = CR_GT;
    else                                    cr = CR_EQ;
  end

  always_comb begin
    int_vld_d   = accept & !in_is_float;
    int_res_d   = '{data: alu, cr: cr, tag: in_tag};
    fl_vld_d    = '0;
    fl_tag_d    = fl_tag_q;
    fl_vld_d[0] = fpu_in_valid;
    fl_tag_d[0] = in_tag;
    for (int i = 1; i < FLAT; i++) begin
      fl_vld_d[i] = fl_vld_q[i-1];
      fl_tag_d[i] = fl_tag_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_vld_q <= 1'b0;
      int_res_q <= '0;
      fl_vld_q  <= '0;
      fl_tag_q  <= '0;
    end else begin
      int_vld_q <= int_vld_d;
      int_res_q <= int_res_d;
      fl_vld_q  <= fl_vld_d;
      fl_tag_q  <= fl_tag_d;
    end
  end

  // The order rule keeps the integer stage and the FPU tail from landing together.
  always_comb begin
    wr_en    = int_vld_q | fl_vld_q[FLAT-1];
    wr_entry = int_vld_q ? int_res_q
                         : '{data: fpu_result, cr: fpu_cr, tag: fl_tag_q[FLAT-1]};
    rd_en    = out_valid & out_ready;
  end

  result_fifo #(.DEPTH(DEPTH), .W($bits(entry_t))) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_entry),
    .rd_en   (rd_en),
    .rd_data (rd_entry),
    .count   (fifo_count)
  );

  assign out_valid = (fifo_count != '0);
  assign out_data  = out_valid ? rd_entry.data : '0;
  assign out_cr    = out_valid ? rd_entry.cr   : '0;
  assign out_tag   = out_valid ? rd_entry.tag  : '0;
endmodule

// File: tb/tb_execute_pipe.sv
// Scoreboard bench for execute_pipe with a behavioural fixed-latency FPU.
module tb_execute_pipe;
  localparam int XLEN = 32, FLAT = 4, DEPTH = 4, TAGW = 5;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  cr;
    logic [4:0]  tag;
  } exp_t;

  logic clk, rst;
  logic in_valid, in_ready, in_is_float;
  logic [3:0] in_op;
  logic [31:0] in_a, in_b;
  logic [4:0] in_tag;
  logic fpu_in_valid;
  logic [3:0] fpu_op, fpu_cr;
  logic [31:0] fpu_a, fpu_b, fpu_result;
  logic out_valid, out_ready;
  logic [31:0] out_data;
  logic [3:0] out_cr;
  logic [4:0] out_tag;

  exp_t sb[$];
  int checks = 0, errors = 0;

  execute_pipe #(.XLEN(XLEN), .FLAT(FLAT), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_is_float(in_is_float), .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .fpu_in_valid(fpu_in_valid), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_result(fpu_result), .fpu_cr(fpu_cr), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_cr(out_cr), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t fmodel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] tag);
    fmodel = '{(a * 32'd3) ^ b ^ {28'd0, op}, a[3:0] ^ op, tag};
  endfunction

  function automatic exp_t imodel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] tag);
    logic [31:0] d;
    logic [3:0]  c;
    logic [4:0]  s;
    s = b[4:0];
    case (op[2:0])
      3'd0: d = a + b;
      3'd1: d = a - b;
      3'd2: d = a & b;
      3'd3: d = a | b;
      3'd4: d = a ^ b;
      3'd5: d = a << s;
      3'd6: d = a >> s;
      default: begin
        d = a >> s;
        if (a[31]) d = d | ~(32'hFFFF_FFFF >> s);
      end
    endcase
    if ($signed(a) < $signed(b))      c = 4'b1000;
    else if ($signed(a) > $signed(b)) c = 4'b0100;
    else                              c = 4'b0010;
    imodel = '{d, c, tag};
  endfunction

  // External FPU: result appears FLAT cycles after the issue edge; keeps running through reset.
  exp_t fp_pipe [FLAT];
  always @(posedge clk) begin
    for (int i = FLAT-1; i > 0; i--) fp_pipe[i] <= fp_pipe[i-1];
    fp_pipe[0] <= fpu_in_valid ? fmodel(fpu_op, fpu_a, fpu_b, 5'd0) : '{32'hDEAD_BEEF, 4'hF, 5'd0};
  end
  assign fpu_result = fp_pipe[FLAT-1].data;
  assign fpu_cr     = fp_pipe[FLAT-1].cr;

  always @(posedge clk) begin : mon
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) chk("spurious_out", 64'(out_valid), 64'd0);
      else begin
        e = sb.pop_front();
        chk("out_data", 64'(out_data), 64'(e.data));
        chk("out_cr",   64'(out_cr),   64'(e.cr));
        chk("out_tag",  64'(out_tag),  64'(e.tag));
      end
    end
  end

  task automatic send(input logic fl, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, input exp_t e, output int waits);
    @(negedge clk);
    in_is_float = fl; in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    waits = 0;
    #1;
    while (!in_ready && waits < 100) begin
      @(negedge clk); #1;
      waits++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    if (fl) begin
      chk("fpu_issue", 64'(fpu_in_valid), 64'd1);
      chk("fpu_a",     64'(fpu_a),        64'(a));
      chk("fpu_op",    64'(fpu_op),       64'(op));
    end
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin : main
    int w, tot, acc;
    logic [3:0] op;
    logic [31:0] a, b;
    rst = 1'b1; in_valid = 1'b0; in_is_float = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    in_tag = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_cr",    64'(out_cr),    64'd0);
    chk("rst_out_tag",   64'(out_tag),   64'd0);
    chk("rst_fpu_valid", 64'(fpu_in_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    @(negedge clk) rst = 1'b0;

    // add 5 + (-3): one-cycle latency into the FIFO
    send(1'b0, 4'd0, 32'd5, 32'hFFFF_FFFD, 5'd7, '{32'd2, 4'b0100, 5'd7}, w);
    @(negedge clk); chk("int_lat_early", 64'(out_valid), 64'd0);
    @(negedge clk); chk("int_lat_valid", 64'(out_valid), 64'd1);
    wait_drain();

    send(1'b0, 4'd7, 32'h8000_0000, 32'd4, 5'd3, '{32'hF800_0000, 4'b1000, 5'd3}, w);
    send(1'b0, 4'd5, 32'h8000_0000, 32'd4, 5'd4, '{32'h0000_0000, 4'b1000, 5'd4}, w);
    wait_drain();

    // random integer stream: full throughput, model-checked results
    tot = 0;
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(0, 7));
      a  = $urandom();
      b  = (i % 5 == 0) ? a : $urandom();
      send(1'b0, op, a, b, 5'(i), imodel(op, a, b, 5'(i)), w);
      tot += w;
    end
    chk("int_throughput_stalls", 64'(tot), 64'd0);
    wait_drain();

    // float then integer: integer waits for the float to reach the FIFO
    send(1'b1, 4'h9, 32'h1234, 32'h55, 5'd1, fmodel(4'h9, 32'h1234, 32'h55, 5'd1), w);
    send(1'b0, 4'd0, 32'd10, 32'd20, 5'd2, imodel(4'd0, 32'd10, 32'd20, 5'd2), w);
    chk("float_int_stall", 64'(w), 64'(FLAT));
    wait_drain();

    // six floats offered with writeback stalled: only DEPTH accepted
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (acc < 6) begin
        in_is_float = 1'b1; in_op = 4'h3; in_a = 32'(c * 7 + 1); in_b = 32'h0F0F;
        in_tag = 5'(10 + acc); in_valid = 1'b1;
        #1;
        if (in_ready) begin
          sb.push_back(fmodel(in_op, in_a, in_b, in_tag));
          acc++;
        end
      end
    end
    in_valid = 1'b0;
    chk("burst_accepted", 64'(acc), 64'(DEPTH));
    chk("burst_ready_low", 64'(in_ready), 64'd0);
    chk("burst_out_valid", 64'(out_valid), 64'd1);
    @(negedge clk) out_ready = 1'b1;
    wait_drain();

    // pop and write on the same edge: credit returns one cycle later
    @(negedge clk) out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(1'b0, 4'd2, 32'hFF00 + 32'(i), 32'h0FF0, 5'(20 + i),
           imodel(4'd2, 32'hFF00 + 32'(i), 32'h0FF0, 5'(20 + i)), w);
    send(1'b1, 4'h1, 32'hABC, 32'h3, 5'd23, fmodel(4'h1, 32'hABC, 32'h3, 5'd23), w);
    for (int k = 1; k <= FLAT; k++) begin
      @(negedge clk); #1;
      chk("full_ready_low", 64'(in_ready), 64'd0);
      if (k == FLAT) begin
        out_ready = 1'b1;
        #1 chk("no_early_credit", 64'(in_ready), 64'd0);
      end
    end
    @(negedge clk) out_ready = 1'b0;
    #1;
    chk("credit_return", 64'(in_ready), 64'd1);
    chk("count_kept_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    wait_drain();

    // reset with 1 FIFO entry and 2 floats in flight
    out_ready = 1'b0;
    send(1'b0, 4'd0, 32'd1, 32'd1, 5'd24, imodel(4'd0, 32'd1, 32'd1, 5'd24), w);
    send(1'b1, 4'h2, 32'h77, 32'h1, 5'd25, fmodel(4'h2, 32'h77, 32'h1, 5'd25), w);
    send(1'b1, 4'h2, 32'h78, 32'h1, 5'd26, fmodel(4'h2, 32'h78, 32'h1, 5'd26), w);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready",  64'(in_ready),  64'd0);
    chk("midrst_out_tag",   64'(out_tag),   64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_idle", 64'(out_valid), 64'd0);
    end
    send(1'b1, 4'h6, 32'h4242, 32'h9, 5'd27, fmodel(4'h6, 32'h4242, 32'h9, 5'd27), w);
    send(1'b0, 4'd1, 32'd3, 32'd9, 5'd28, imodel(4'd1, 32'd3, 32'd9, 5'd28), w);
    wait_drain();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
